sp_ram_bank_ctrl: RTL



---
 rtl/sp_ram_bank_ctrl_if.sv | 25 ++
 rtl/sp_ram_bank_ctrl.sv | 101 ++++++++++
 2 files changed

// File: rtl/sp_ram_bank_ctrl_if.sv
// Request/grant bus between a core/interconnect master and the SRAM bank controller.
// Signal names carry the controller-side direction suffixes.
interface sp_ram_bank_ctrl_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  logic                    req_i;
  logic                    gnt_o;
  logic [ADDR_WIDTH-1:0]   addr_i;
  logic                    we_i;
  logic [DATA_WIDTH/8-1:0] be_i;
  logic [DATA_WIDTH-1:0]   wdata_i;
  logic                    rvalid_o;
  logic [DATA_WIDTH-1:0]   rdata_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/sp_ram_bank_ctrl.sv
// Front end for one 4096 x 32 byte-writable single-port SRAM bank, with a
// RUN/DRAIN/BIST interlock that hands the bank to memory BIST when idle.
module sp_ram_bank_ctrl #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    CK,
  input  logic                    RST,
  sp_ram_bank_ctrl_if.slave       bus,
  output logic [ADDR_WIDTH-3:0]   A,
  output logic [DATA_WIDTH-1:0]   DI,
  output logic [DATA_WIDTH/8-1:0] WEB,
  input  logic [DATA_WIDTH-1:0]   DO,
  input  logic                    mbist_req_i,
  output logic                    mbist_ack_o
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    BIST  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-3:0]   a_q, a_d;
  logic [DATA_WIDTH-1:0]   di_q, di_d;
  logic                    rvalid_q, rvalid_d;
  logic                    rd_pend_q, rd_pend_d;
  logic [DATA_WIDTH-1:0]   rdata_hold_q, rdata_hold_d;
  logic                    ack_q, ack_d;
  logic                    gnt;
  logic                    issue;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    unused_addr_bits;

  assign unused_addr_bits = ^bus.addr_i[1:0];

  // BIST always wins over a same-cycle request; reset also blocks the grant.
  assign gnt   = !RST && (state_q == RUN) && !mbist_req_i && bus.req_i;
  assign issue = bus.req_i && gnt;

  // Bank port is driven combinationally on issue so the SRAM samples on the same edge.
  always_comb begin
    a_d  = a_q;
    di_d = di_q;
    WEB  = '1;
    if (issue) begin
      a_d  = bus.addr_i[ADDR_WIDTH-1:2];
      di_d = bus.wdata_i;
      if (bus.we_i) begin
        WEB = ~bus.be_i;
      end
    end
    A  = a_d;
    DI = di_d;
  end

  always_comb begin
    rvalid_d     = issue;
    rd_pend_d    = issue && !bus.we_i;
    rdata        = (rvalid_q && rd_pend_q) ? DO : rdata_hold_q;
    rdata_hold_d = rdata;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (mbist_req_i) state_d = DRAIN;
      DRAIN:   state_d = mbist_req_i ? BIST : RUN;
      BIST:    if (!mbist_req_i) state_d = RUN;
      default: state_d = RUN;
    endcase
    ack_d = (state_d == BIST);
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q      <= RUN;
      a_q          <= '0;
      di_q         <= '0;
      rvalid_q     <= 1'b0;
      rd_pend_q    <= 1'b0;
      rdata_hold_q <= '0;
      ack_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      di_q         <= di_d;
      rvalid_q     <= rvalid_d;
      rd_pend_q    <= rd_pend_d;
      rdata_hold_q <= rdata_hold_d;
      ack_q        <= ack_d;
    end
  end

  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = rvalid_q;
  assign bus.rdata_o  = rdata;
  assign mbist_ack_o  = ack_q;

endmodule
